// File: rtl/line_raster_if.sv
// line_raster_if: command, pixel stream and status bundle for the line rasteriser.
interface line_raster_if #(parameter int CW = 8);
  logic start, skip_last, abort, pix_valid, pix_ready, busy, done;
  logic [CW-1:0] x0, y0, x1, y1, pix_x, pix_y;
  logic [CW:0] pix_count;
  modport master (output start, skip_last, abort, x0, y0, x1, y1, pix_ready,
                  input pix_x, pix_y, pix_valid, busy, done, pix_count);
  modport slave (input start, skip_last, abort, x0, y0, x1, y1, pix_ready,
                 output pix_x, pix_y, pix_valid, busy, done, pix_count);
endinterface

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser emitting pixels on a valid/ready stream.
module line_raster #(parameter int CW = 8) (
  input logic clk,
  input logic rst_n,
  line_raster_if.slave lr
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;
  localparam logic signed [CW+1:0] ZERO = '0;
  state_t state, state_nx;
  logic [CW-1:0] xs, ys, xe, ye, x, y, stepx, stepy, nx, ny;
  logic skip, hs, at_end, nx_end;
  logic [CW:0] count;
  logic signed [CW+1:0] err, e2, dx, dy, nerr;
  always_comb begin
    dx = $signed({2'b00, xs > xe ? xs - xe : xe - xs});
    dy = -$signed({2'b00, ys > ye ? ys - ye : ye - ys});
    stepx = xs < xe ? CW'(1) : '1;
    stepy = ys < ye ? CW'(1) : '1;
    e2 = err <<< 1;
    nerr = err + (e2 >= dy ? dy : ZERO) + (e2 <= dx ? dx : ZERO);
    nx = e2 >= dy ? x + stepx : x;
    ny = e2 <= dx ? y + stepy : y;
    hs = state == DRAW && lr.pix_ready;
    at_end = x == xe && y == ye;
    nx_end = nx == xe && ny == ye;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (lr.start ? SETUP : IDLE)
      : lr.abort && state != FINISH ? IDLE
      : state == SETUP ? (skip && xs == xe && ys == ye ? FINISH : DRAW)
      : state == DRAW ? (hs && (at_end || (skip && nx_end)) ? FINISH : DRAW)
      : IDLE;
  end
  always_comb begin
    lr.pix_valid = state == DRAW;
    lr.busy = state == SETUP || state == DRAW;
    lr.done = state == FINISH;
  end
  assign lr.pix_x = x;
  assign lr.pix_y = y;
  assign lr.pix_count = count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xs <= '0;
      ys <= '0;
      xe <= '0;
      ye <= '0;
      x <= '0;
      y <= '0;
      err <= '0;
      skip <= 1'b0;
      count <= '0;
    end else begin
      if (state == IDLE && lr.start) begin
        xs <= lr.x0;
        ys <= lr.y0;
        xe <= lr.x1;
        ye <= lr.y1;
        skip <= lr.skip_last;
        count <= '0;
      end
      if (state == SETUP) begin
        x <= xs;
        y <= ys;
        err <= dx + dy;
      end
      if (hs) count <= count + (CW+1)'(1);
      // the endpoint is terminal, so the point is never stepped past it
      if (hs && !at_end) begin
        x <= nx;
        y <= ny;
        err <= nerr;
      end
    end
endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Parametrised Bresenham line rasteriser; successor to the team's diagonal-step line drawer.
- Emits every pixel of an exact Bresenham line from (x0,y0) to (x1,y1) on a valid/ready output stream, so downstream framebuffer or SPI writers can apply backpressure.
- Adds configurable coordinate width, abort, a pixel counter and an optional endpoint-skip mode for polyline chaining.

Parameters:
- CW, 8, coordinate width in bits; unsigned coordinates 0..2^CW-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request; sampled only in IDLE
- skip_last  in  1  sampled with start; 1 = do not emit endpoint pixel (polyline chaining)
- abort  in  1  terminate current line
- x0, y0  in  CW  start point
- x1, y1  in  CW  end point
- pix_x, pix_y  out  CW  current pixel
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse, line complete
- pix_count  out  CW+1  pixels emitted for the current or last line

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers 0. Reset mid-line drops the line immediately. No done is issued.
- States: IDLE, SETUP, DRAW, FINISH.
- IDLE:
  - start=1 latches the endpoints and skip_last.
  - Clears pix_count.
  - Sets busy; next state is SETUP.
  - start is ignored in every other state.
- SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy likewise.
  - err = dx+dy.
  - Signed arithmetic is CW+2 bits wide; e2 = 2*err is computed in the same width with no overflow.
  - Current point = (x0,y0).
  - If skip_last=1 and the endpoints are equal, the next state is FINISH. Otherwise it is DRAW.
- DRAW:
  - pix_valid=1 with pix_x/pix_y equal to the current point. The first pixel is valid 2 cycles after the start cycle.
  - Outputs hold stable while pix_valid=1 and pix_ready=0.
  - On handshake (pix_valid & pix_ready):
    - pix_count increments.
    - If the current point equals the endpoint, the next state is FINISH.
    - Otherwise apply, both from the old err:
      - if e2 >= dy: err += dy, x += sx
      - if e2 <= dx: err += dx, y += sy
    - If skip_last=1 and the new point equals the endpoint, the next state is FINISH instead of emitting it.
  - Sustained throughput is 1 pixel/cycle when pix_ready is held high.
- FINISH: done=1 for one cycle; busy=0; pix_valid=0; next state IDLE. pix_count holds its value until the next start.
- abort:
  - abort=1 in SETUP or DRAW forces IDLE on the next edge.
  - pix_valid and busy drop; done is not pulsed; pix_count holds.
  - A handshake in the same cycle as abort still counts.
  - abort in IDLE or FINISH has no effect.
- Line lengths:
  - Pixel count is max(dx,|dy|)+1, or one fewer with skip_last.
  - The maximum is 2^CW, which fits in pix_count.
  - Coordinates never leave the range between the endpoints, so there is no wrap-around.
- Endpoint inputs may change freely after the start cycle.

Test Plan:
- (0,0)->(0,0), pix_ready=1:
  - exactly one pixel (0,0), 2 cycles after start;
  - done on the cycle after the handshake;
  - pix_count=1.
- (0,0)->(5,2), pix_ready=1:
  - pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on consecutive cycles;
  - pix_count=6; done once.
- (5,2)->(0,0): pixels (5,2),(4,2),(3,1),(2,1),(1,0),(0,0). Also (2,0)->(2,4): x constant, y 0..4.
- (0,0)->(5,2) with pix_ready toggling randomly:
  - same 6-pixel sequence;
  - pix_x/pix_y stable while stalled;
  - no pixel dropped or duplicated.
- CW=8, (0,0)->(255,255): 256 diagonal pixels; pix_count=256 (9-bit).
- skip_last=1, (0,0)->(3,0): pixels (0,0),(1,0),(2,0); pix_count=3.
- abort asserted after 3 handshakes on (0,0)->(10,0): IDLE next cycle, no done, pix_count=3. A new start then runs normally.
- rst_n pulsed mid-line: all outputs 0 immediately.
